// File: rtl/if_id_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// if_id_pipe_ctrl
//
// Consumer side of the load-use hazard interface in a 5-stage MIPS pipeline.
// It applies the hazard unit's PCWrite / IF_ID_Write / stall levels to the PC,
// the IF/ID pipeline register and the ID/EX control bundle, and it also
// squashes the wrong-path fetch when a branch resolves taken in ID.
//
// Per-edge priority: stall > branch_taken > normal.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   PCWrite           1 = PC may advance this cycle (normal cycles only)
//   IF_ID_Write       1 = IF/ID may load this cycle (normal cycles only)
//   stall             1 = bubble into ID/EX, freeze PC and IF/ID
//   branch_taken      branch resolved taken in ID
//   branch_target     PC for a taken branch (used as given)
//   instr_in          IMEM read data at pc
//   id_ctrl_in        control bundle from the main decoder
//   pc                current fetch PC
//   if_id_pc_plus4    registered PC+4
//   if_id_instr       registered instruction (0 = NOP)
//   if_id_valid       IF/ID holds a real instruction
//   id_ex_ctrl        control bundle entering ID/EX (all-zero = bubble)
//   id_ex_bubble      bubble was issued into ID/EX on the last edge
//   pipe_state        00 RUN, 01 STALLED, 10 FLUSH (reflects the last edge)
//   stall_err         sticky: a stall lasted more than MAX_STALL edges
//
// Build option
//   STALL_PERF_CNT_EN  adds stall_cycles / flush_cycles 32-bit counters that
//                      wrap at 2^32 and are cleared only by rst.
// -----------------------------------------------------------------------------
module if_id_pipe_ctrl #(
    parameter int              PC_W      = 32,
    parameter int              INSTR_W   = 32,
    parameter int              CTRL_W    = 9,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              MAX_STALL = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PCWrite,
    input  logic               IF_ID_Write,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [CTRL_W-1:0]  id_ctrl_in,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    if_id_pc_plus4,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid,
    output logic [CTRL_W-1:0]  id_ex_ctrl,
    output logic               id_ex_bubble,
    output logic [1:0]         pipe_state,
    output logic               stall_err
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        flush_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_STALLED = 2'b01,
        ST_FLUSH   = 2'b10
    } state_e;

    // Counter must be able to hold MAX_STALL+1, its saturation value.
    localparam int             CNT_W   = $clog2(MAX_STALL + 2);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_STALL + 1);

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [PC_W-1:0]      if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic [INSTR_W-1:0]   if_id_instr_q, if_id_instr_d;
    logic                 if_id_valid_q, if_id_valid_d;
    logic                 id_ex_bubble_q, id_ex_bubble_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic                 stall_err_q, stall_err_d;
    logic [PC_W-1:0]      pc_plus4;

    // Modulo 2^PC_W: 0xFFFFFFFC + 4 wraps to 0 by truncation.
    assign pc_plus4 = pc_q + PC_W'(4);

    // -------------------------------------------------------------------------
    // Datapath next-state
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a hold default first so no path through the
        // if/else leaves it unassigned, which would infer a latch.
        pc_d             = pc_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_valid_d    = if_id_valid_q;
        id_ex_bubble_d   = 1'b0;

        if (stall) begin
            // Branch operands are not valid yet, so branch_taken is ignored.
            id_ex_bubble_d = 1'b1;
        end else if (branch_taken) begin
            // One-cycle squash of the wrong-path fetch.
            pc_d             = branch_target;
            if_id_pc_plus4_d = '0;
            if_id_instr_d    = '0;
            if_id_valid_d    = 1'b0;
        end else begin
            if (PCWrite) begin
                pc_d = pc_plus4;
            end
            if (IF_ID_Write) begin
                if_id_pc_plus4_d = pc_plus4;
                if_id_instr_d    = instr_in;
                if_id_valid_d    = 1'b1;
            end
        end
    end

    // Stall watchdog: counts consecutive stalled edges, saturating one past
    // the tolerated limit; the error flag is sticky until reset.
    always_comb begin
        stall_cnt_d = '0;
        if (stall) begin
            stall_cnt_d = (stall_cnt_q == CNT_SAT) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
        end
        stall_err_d = stall_err_q | (stall_cnt_d == CNT_SAT);
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (stall)             state_d = ST_STALLED;
                else if (branch_taken) state_d = ST_FLUSH;
            end
            ST_STALLED: begin
                if (stall)             state_d = ST_STALLED;
                else if (branch_taken) state_d = ST_FLUSH;
                else                   state_d = ST_RUN;
            end
            ST_FLUSH: begin
                if (stall)             state_d = ST_STALLED;
                else if (branch_taken) state_d = ST_FLUSH;
                else                   state_d = ST_RUN;
            end
            default:                   state_d = ST_RUN;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q             <= RESET_PC;
            if_id_pc_plus4_q <= '0;
            if_id_instr_q    <= '0;
            if_id_valid_q    <= 1'b0;
            id_ex_bubble_q   <= 1'b0;
            stall_cnt_q      <= '0;
            stall_err_q      <= 1'b0;
        end else begin
            pc_q             <= pc_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_valid_q    <= if_id_valid_d;
            id_ex_bubble_q   <= id_ex_bubble_d;
            stall_cnt_q      <= stall_cnt_d;
            stall_err_q      <= stall_err_d;
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_cycles_q, flush_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_cycles_d = flush_cycles_q;
        if (stall) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end else if (branch_taken) begin
            flush_cycles_d = flush_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_cycles_q <= flush_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_cycles = flush_cycles_q;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        pipe_state = state_q;
    end

    // Zero latency: the bubble enters ID/EX on the same edge stall is sampled.
    assign id_ex_ctrl     = stall ? '0 : id_ctrl_in;
    assign pc             = pc_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_valid    = if_id_valid_q;
    assign id_ex_bubble   = id_ex_bubble_q;
    assign stall_err      = stall_err_q;

endmodule
